slice_sequencer: RTL and testbench

//  Top-level controller of the slicer. On start it measures object length (HC-SR04

---
 rtl/slicer_pkg.sv | 33 +++
 rtl/seq_divider.sv | 81 ++++++++
 rtl/slice_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_slice_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slicer_pkg.sv
// Shared types and defaults for the slicer controller: state encoding, slice-count
// width and the helpers used by the sequencer.
package slicer_pkg;

    localparam int unsigned SLICE_NUM_W      = 5;
    localparam int unsigned SLICE_NUM_MAX    = 31;
    localparam int unsigned DIST_W_DEF       = 16;
    localparam int unsigned STEP_W_DEF       = 24;
    localparam int unsigned STEPS_PER_MM_DEF = 8;
    localparam int unsigned MIN_MM_DEF       = 10;
    localparam int unsigned MEAS_TIMEOUT_DEF = 3000000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MEAS,
        S_DIV,
        S_ADV,
        S_CUT_DN,
        S_CUT_UP,
        S_RET,
        S_DONE,
        S_ERR
    } slice_state_e;

    function automatic logic [SLICE_NUM_W-1:0] next_slice_num(input logic [SLICE_NUM_W-1:0] n);
        return (n == SLICE_NUM_W'(SLICE_NUM_MAX)) ? SLICE_NUM_W'(1) : n + SLICE_NUM_W'(1);
    endfunction

    function automatic logic state_is_busy(input slice_state_e s);
        return !(s == S_IDLE || s == S_DONE || s == S_ERR);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: DIST_W-bit dividend by slice-count divisor, one quotient bit per cycle.
module seq_divider
    import slicer_pkg::*;
#(
    parameter int unsigned DIST_W = DIST_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [DIST_W-1:0]      dividend_i,
    input  logic [SLICE_NUM_W-1:0] divisor_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DIST_W-1:0]      quotient_o
);

    localparam int unsigned CNT_W = $clog2(DIST_W + 1);
    localparam int unsigned TRY_W = SLICE_NUM_W + 1;

    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [DIST_W-1:0]      quo_q, quo_d;
    logic [SLICE_NUM_W-1:0] rem_q, rem_d;
    logic [SLICE_NUM_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [TRY_W-1:0]       trial_c;

    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        trial_c = {rem_q, quo_q[DIST_W-1]};
        if (start_i && !busy_q) begin
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
            cnt_d  = CNT_W'(DIST_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial_c >= {1'b0, dvs_q}) begin
                rem_d = SLICE_NUM_W'(trial_c - {1'b0, dvs_q});
                quo_d = {quo_q[DIST_W-2:0], 1'b1};
            end else begin
                rem_d = trial_c[SLICE_NUM_W-1:0];
                quo_d = {quo_q[DIST_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/slice_sequencer.sv
// Slicer top controller: measure, divide, then advance/cut per slice and return home,
// driving mover and cutter through req/done handshakes.
module slice_sequencer
    import slicer_pkg::*;
#(
    parameter int unsigned DIST_W       = DIST_W_DEF,
    parameter int unsigned STEP_W       = STEP_W_DEF,
    parameter int unsigned STEPS_PER_MM = STEPS_PER_MM_DEF,
    parameter int unsigned MIN_MM       = MIN_MM_DEF,
    parameter int unsigned MEAS_TIMEOUT = MEAS_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              pause_i,
    input  logic              slice_i,
    output logic              meas_req_o,
    input  logic              dist_valid_i,
    input  logic [DIST_W-1:0] dist_mm_i,
    output logic              mv_req_o,
    output logic              mv_dir_o,
    output logic [STEP_W-1:0] mv_steps_o,
    input  logic              mv_done_i,
    output logic              cut_req_o,
    output logic              cut_dir_o,
    input  logic              cut_done_i,
    output logic [4:0]        slice_num_o,
    output logic              busy_o,
    output logic              paused_o,
    output logic              finish_o,
    output logic              err_o
);

    localparam int unsigned TMR_W  = $clog2(MEAS_TIMEOUT + 1);
    localparam int unsigned PROD_W = DIST_W + STEP_W;

    slice_state_e           state_q, state_d;
    logic [SLICE_NUM_W-1:0] slice_num_q, slice_num_d;
    logic [SLICE_NUM_W-1:0] slice_cnt_q, slice_cnt_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [STEP_W-1:0]      acc_q, acc_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   pend_q, pend_d;
    logic                   paused_q, paused_d;
    logic                   meas_req_q, meas_req_d;
    logic                   mv_req_q, mv_req_d, mv_dir_q, mv_dir_d;
    logic [STEP_W-1:0]      mv_steps_q, mv_steps_d;
    logic                   cut_req_q, cut_req_d, cut_dir_q, cut_dir_d;
    logic                   busy_q, busy_d, finish_q, finish_d, err_q, err_d;

    logic                   div_start_c, div_busy, div_done;
    logic [DIST_W-1:0]      div_quot;
    logic [PROD_W-1:0]      prod_c;
    logic [STEP_W-1:0]      step_sat_c;
    logic [STEP_W:0]        acc_sum_c;
    logic [STEP_W-1:0]      acc_sat_c;
    logic [SLICE_NUM_W-1:0] cnt_inc_c;
    logic                   evt_c;

    seq_divider #(.DIST_W(DIST_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start_c),
        .dividend_i (dist_mm_i),
        .divisor_i  (slice_num_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    assign prod_c     = PROD_W'(div_quot) * PROD_W'(STEPS_PER_MM);
    assign step_sat_c = (|prod_c[PROD_W-1:STEP_W]) ? '1 : prod_c[STEP_W-1:0];
    assign acc_sum_c  = {1'b0, acc_q} + {1'b0, step_q};
    assign acc_sat_c  = acc_sum_c[STEP_W] ? '1 : acc_sum_c[STEP_W-1:0];
    assign cnt_inc_c  = slice_cnt_q + SLICE_NUM_W'(1);

    // Next state; a done seen while paused is parked in pend_q until unpause.
    always_comb begin
        state_d     = state_q;
        slice_num_d = slice_num_q;
        slice_cnt_d = slice_cnt_q;
        step_d      = step_q;
        acc_d       = acc_q;
        timer_d     = timer_q;
        pend_d      = pend_q;
        paused_d    = paused_q;
        meas_req_d  = 1'b0;
        mv_req_d    = mv_req_q;
        mv_dir_d    = mv_dir_q;
        mv_steps_d  = mv_steps_q;
        cut_req_d   = cut_req_q;
        cut_dir_d   = cut_dir_q;
        div_start_c = 1'b0;
        evt_c       = 1'b0;

        if (state_is_busy(state_q) && pause_i) paused_d = !paused_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d     = S_MEAS;
                    meas_req_d  = 1'b1;
                    paused_d    = 1'b0;
                    slice_cnt_d = '0;
                    acc_d       = '0;
                    timer_d     = '0;
                    pend_d      = 1'b0;
                end else if (slice_i) begin
                    slice_num_d = next_slice_num(slice_num_q);
                end
            end
            S_MEAS: begin
                if (dist_valid_i) begin
                    if (dist_mm_i < DIST_W'(MIN_MM)) begin
                        state_d = S_ERR;
                    end else begin
                        div_start_c = 1'b1;
                        state_d     = S_DIV;
                    end
                end else if (!paused_q) begin
                    if (timer_q == TMR_W'(MEAS_TIMEOUT - 1)) state_d = S_ERR;
                    else timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DIV: begin
                if (div_done && !div_busy) begin
                    if (div_quot == '0) begin
                        state_d = S_ERR;
                    end else begin
                        step_d  = step_sat_c;
                        state_d = S_ADV;
                    end
                end
            end
            S_ADV, S_RET: begin
                evt_c = (mv_req_q && mv_done_i) || pend_q;
                if (mv_req_q && mv_done_i) mv_req_d = 1'b0;
                if (evt_c) begin
                    pend_d = paused_d;
                    if (!paused_d) begin
                        if (state_q == S_ADV) begin
                            acc_d   = acc_sat_c;
                            state_d = S_CUT_DN;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end else if (!mv_req_q && !paused_d) begin
                    mv_req_d   = 1'b1;
                    mv_dir_d   = (state_q == S_ADV);
                    mv_steps_d = (state_q == S_ADV) ? step_q : acc_q;
                end
            end
            S_CUT_DN, S_CUT_UP: begin
                evt_c = (cut_req_q && cut_done_i) || pend_q;
                if (cut_req_q && cut_done_i) cut_req_d = 1'b0;
                if (evt_c) begin
                    pend_d = paused_d;
                    if (!paused_d) begin
                        if (state_q == S_CUT_DN) begin
                            state_d = S_CUT_UP;
                        end else begin
                            slice_cnt_d = cnt_inc_c;
                            state_d     = (cnt_inc_c == slice_num_q) ? S_RET : S_ADV;
                        end
                    end
                end else if (!cut_req_q && !paused_d) begin
                    cut_req_d = 1'b1;
                    cut_dir_d = (state_q == S_CUT_DN);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d   = state_is_busy(state_d);
        finish_d = (state_d == S_DONE);
        err_d    = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            slice_num_q <= SLICE_NUM_W'(1);
            slice_cnt_q <= '0;
            step_q      <= '0;
            acc_q       <= '0;
            timer_q     <= '0;
            pend_q      <= 1'b0;
            paused_q    <= 1'b0;
            meas_req_q  <= 1'b0;
            mv_req_q    <= 1'b0;
            mv_dir_q    <= 1'b0;
            mv_steps_q  <= '0;
            cut_req_q   <= 1'b0;
            cut_dir_q   <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slice_num_q <= slice_num_d;
            slice_cnt_q <= slice_cnt_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            paused_q    <= paused_d;
            meas_req_q  <= meas_req_d;
            mv_req_q    <= mv_req_d;
            mv_dir_q    <= mv_dir_d;
            mv_steps_q  <= mv_steps_d;
            cut_req_q   <= cut_req_d;
            cut_dir_q   <= cut_dir_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
            err_q       <= err_d;
        end
    end

    assign meas_req_o  = meas_req_q;
    assign mv_req_o    = mv_req_q;
    assign mv_dir_o    = mv_dir_q;
    assign mv_steps_o  = mv_steps_q;
    assign cut_req_o   = cut_req_q;
    assign cut_dir_o   = cut_dir_q;
    assign slice_num_o = slice_num_q;
    assign busy_o      = busy_q;
    assign paused_o    = paused_q;
    assign finish_o    = finish_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_slice_sequencer.sv
// Scoreboard bench for slice_sequencer: expected mover/cutter requests are queued per run
// from a length/count model and matched by a monitor as the DUT raises each request.
module tb_slice_sequencer;

    localparam int unsigned DW = 16, SW = 24, SPM = 8, MINMM = 10, TMO = 100;

    typedef struct packed {
        logic          is_mv;
        logic          dir;
        logic [SW-1:0] steps;
    } req_t;

    logic clk = 1'b0, rst = 1'b1;
    logic start_i = 0, pause_i = 0, slice_i = 0;
    logic meas_req_o, dist_valid_i = 0;
    logic [DW-1:0] dist_mm_i = '0;
    logic mv_req_o, mv_dir_o, mv_done_i = 0;
    logic [SW-1:0] mv_steps_o;
    logic cut_req_o, cut_dir_o, cut_done_i = 0;
    logic [4:0] slice_num_o;
    logic busy_o, paused_o, finish_o, err_o;

    int checks = 0, failures = 0;
    req_t exp_q[$];
    int model_slices = 1;
    logic meas_en = 1'b1;
    logic [DW-1:0] meas_dist = '0;

    always #5 clk = ~clk;

    slice_sequencer #(.DIST_W(DW), .STEP_W(SW), .STEPS_PER_MM(SPM), .MIN_MM(MINMM),
                      .MEAS_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pause_i(pause_i), .slice_i(slice_i),
        .meas_req_o(meas_req_o), .dist_valid_i(dist_valid_i), .dist_mm_i(dist_mm_i),
        .mv_req_o(mv_req_o), .mv_dir_o(mv_dir_o), .mv_steps_o(mv_steps_o), .mv_done_i(mv_done_i),
        .cut_req_o(cut_req_o), .cut_dir_o(cut_dir_o), .cut_done_i(cut_done_i),
        .slice_num_o(slice_num_o), .busy_o(busy_o), .paused_o(paused_o),
        .finish_o(finish_o), .err_o(err_o)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] sat_steps(input longint v);
        return (v > longint'(24'hFFFFFF)) ? 24'hFFFFFF : SW'(v);
    endfunction

    function automatic req_t mk(input logic is_mv, input logic dir, input logic [SW-1:0] steps);
        req_t r;
        r.is_mv = is_mv;
        r.dir   = dir;
        r.steps = steps;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rising request is matched against the head of the expectation queue.
    initial begin
        logic mv_prev, cut_prev, any_prev;
        req_t got, e;
        mv_prev = 0; cut_prev = 0; any_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst && ((mv_req_o && !mv_prev) || (cut_req_o && !cut_prev))) begin
                check("req_gap", longint'(any_prev), 0);
                check("req_overlap", longint'(mv_req_o & cut_req_o), 0);
                got = (mv_req_o && !mv_prev) ? mk(1'b1, mv_dir_o, mv_steps_o) : mk(1'b0, cut_dir_o, '0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got 0x%0h with nothing expected", got);
                end else begin
                    e = exp_q.pop_front();
                    check("req", longint'(got), longint'(e));
                end
            end
            mv_prev  = mv_req_o;
            cut_prev = cut_req_o;
            any_prev = mv_req_o | cut_req_o;
        end
    end

    // Ultrasonic front end: answers each measurement request after a short random delay.
    initial begin
        forever begin
            tick();
            if (!rst && meas_req_o && meas_en) begin
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1 dist_valid_i = 1'b1;
                dist_mm_i = meas_dist;
                tick();
                dist_valid_i = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            tick();
            if (!rst && mv_req_o) begin
                repeat ($urandom_range(3, 8)) @(posedge clk);
                #1 mv_done_i = 1'b1;
                tick();
                mv_done_i = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            tick();
            if (!rst && cut_req_o) begin
                repeat ($urandom_range(2, 6)) @(posedge clk);
                #1 cut_done_i = 1'b1;
                tick();
                cut_done_i = 1'b0;
            end
        end
    end

    task automatic pulse_slice();
        slice_i = 1'b1;
        tick();
        slice_i = 1'b0;
        model_slices = (model_slices == 31) ? 1 : model_slices + 1;
    endtask

    task automatic set_slices(input int n);
        while (model_slices != n) pulse_slice();
        tick();
        check("slice_num_set", slice_num_o, model_slices);
    endtask

    task automatic wait_mv_req();
        int k = 0;
        while (!mv_req_o && k < 300) begin tick(); k++; end
        check("mv_req_seen", mv_req_o, 1);
    endtask

    task automatic wait_end(input logic exp_err);
        int k = 0;
        while (!(finish_o || err_o) && k < 5000) begin tick(); k++; end
        check("run_ended", longint'(finish_o | err_o), 1);
        check("finish", finish_o, longint'(!exp_err));
        check("err", err_o, longint'(exp_err));
        check("busy_off", busy_o, 0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // mode: 0 plain, 1 slice/start pulses mid-run, 2 pause around a mover done, 3 start+slice together
    task automatic do_run(input int n, input int d, input int mode);
        logic exp_err;
        logic [SW-1:0] st;
        longint q;
        int k;
        logic seen;
        set_slices(n);
        meas_dist = DW'(d);
        q = longint'(d / n);
        exp_err = (d < int'(MINMM)) || (q == 0);
        st = sat_steps(q * SPM);
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(mk(1'b1, 1'b1, st));
                exp_q.push_back(mk(1'b0, 1'b1, '0));
                exp_q.push_back(mk(1'b0, 1'b0, '0));
            end
            exp_q.push_back(mk(1'b1, 1'b0, sat_steps(longint'(st) * n)));
        end
        start_i = 1'b1;
        if (mode == 3) slice_i = 1'b1;
        tick();
        start_i = 1'b0;
        slice_i = 1'b0;
        check("meas_req_pulse", meas_req_o, 1);
        check("busy_on_start", busy_o, 1);
        check("cleared_on_start", longint'({finish_o, err_o, paused_o}), 0);
        if (mode == 1) begin
            wait_mv_req();
            slice_i = 1'b1; tick(); slice_i = 1'b0;
            start_i = 1'b1; tick(); start_i = 1'b0;
        end
        if (mode == 2) begin
            wait_mv_req();
            pause_i = 1'b1; tick(); pause_i = 1'b0;
            check("paused_set", paused_o, 1);
            k = 0;
            while (mv_req_o && k < 50) begin tick(); k++; end
            check("mv_req_dropped", mv_req_o, 0);
            seen = 1'b0;
            repeat (10) begin tick(); seen |= cut_req_o; end
            check("no_cut_while_paused", seen, 0);
            check("still_paused", paused_o, 1);
            pause_i = 1'b1; tick(); pause_i = 1'b0;
            seen = cut_req_o;
            repeat (2) begin tick(); seen |= cut_req_o; end
            check("cut_after_unpause", seen, 1);
            check("unpaused", paused_o, 0);
        end
        wait_end(exp_err);
        check("slice_num_kept", slice_num_o, model_slices);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_slice_num", slice_num_o, 1);
        check("rst_reqs", longint'({meas_req_o, mv_req_o, cut_req_o}), 0);
        check("rst_flags", longint'({busy_o, paused_o, finish_o, err_o}), 0);
        check("rst_mover", longint'({mv_dir_o, cut_dir_o, mv_steps_o}), 0);

        repeat (30) pulse_slice();
        tick();
        check("slice_31", slice_num_o, 31);
        pulse_slice();
        tick();
        check("slice_wrap", slice_num_o, 1);

        do_run(4, 100, 1);
        do_run(2, 100, 2);

        meas_en = 1'b0;
        start_i = 1'b1; tick(); start_i = 1'b0;
        repeat (50) tick();
        check("no_early_timeout", err_o, 0);
        check("busy_in_meas", busy_o, 1);
        k = 0;
        while (!err_o && k < 80) begin tick(); k++; end
        check("timeout_err", err_o, 1);
        check("timeout_not_busy", busy_o, 0);
        meas_en = 1'b1;
        do_run(2, 60, 0);

        do_run(20, 15, 0);
        do_run(20, 5, 3);

        for (int i = 0; i < 12; i++)
            do_run(int'($urandom_range(1, 6)), int'($urandom_range(0, 400)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
